// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: segment patterns
// (active-low, bit 0 = a ... bit 6 = g), special codes and capture FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the display encoder: active-low segment pattern to
// 4-bit code; unknown patterns give CODE_ERR with err raised.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = CODE_ERR;
        err  = 1'b0;
        case (seg_n)
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_A:     code = 4'hA;
            SEG_B:     code = 4'hB;
            SEG_C:     code = 4'hC;
            SEG_D:     code = 4'hD;
            SEG_BLANK: code = CODE_BLANK;
            default:   err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers per-digit codes from a multiplexed active-low segment bus once a
// sample has been stable long enough. Define SEG7_INPUT_SYNC_EN for async sources.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS    = 4,
    parameter  int STABLE_CYCLES = 4,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    upd_ready,
    input  logic                    ovr_clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    upd_valid,
    output logic [IDX_W-1:0]        upd_idx,
    output logic [3:0]              upd_code,
    output logic                    overrun
);

    localparam int SW = NUM_DIGITS + 7;

    logic [6:0]            seg_in;
    logic [NUM_DIGITS-1:0] sel_in;

`ifdef SEG7_INPUT_SYNC_EN
    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] sel_s1, sel_s2;

    // stage: two-flop synchroniser ahead of the sample register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= SEG_BLANK;
            seg_s2 <= SEG_BLANK;
            sel_s1 <= '0;
            sel_s2 <= '0;
        end else begin
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
            sel_s1 <= dig_sel;
            sel_s2 <= sel_s1;
        end
    end

    assign seg_in = seg_s2;
    assign sel_in = sel_s2;
`else
    assign seg_in = seg_n;
    assign sel_in = dig_sel;
`endif

    function automatic logic [IDX_W-1:0] sel_to_idx(input logic [NUM_DIGITS-1:0] sel);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (sel[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    logic [SW-1:0] samp_p0, samp_p1;
    logic          sel_valid, same;
    logic [3:0]    dec_code;
    logic          dec_err;
    scan_state_e   state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          capture;

    assign samp_p0   = {sel_in, seg_in};
    assign sel_valid = (sel_in != '0) && ((sel_in & (sel_in - NUM_DIGITS'(1))) == '0);
    assign same      = (samp_p0 == samp_p1);

    seg7_pattern_decode u_dec (
        .seg_n (seg_in),
        .code  (dec_code),
        .err   (dec_err)
    );

    // Counting is against the incoming sample, so capture lands on the edge
    // that registers the STABLE_CYCLES-th identical sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!same || state_q == IDLE) begin
            if (sel_valid) begin
                state_d = TRACK;
                cnt_d   = 8'd1;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (state_q == TRACK) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == 8'(STABLE_CYCLES)) begin
                capture = 1'b1;
                state_d = HELD;
            end
        end
    end

    // stage: sample register and window tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_p1 <= {{NUM_DIGITS{1'b0}}, SEG_BLANK};
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            samp_p1 <= samp_p0;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // stage: capture registers and update event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits    <= '1;
            digit_err <= '0;
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            upd_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && sel_in[i]) begin
                    digits[4*i +: 4] <= dec_code;
                    digit_err[i]     <= dec_err;
                end
            end
            if (capture) begin
                upd_valid <= 1'b1;
                upd_idx   <= sel_to_idx(sel_in);
                upd_code  <= dec_code;
            end else if (upd_valid && upd_ready) begin
                upd_valid <= 1'b0;
            end
            if (capture && upd_valid && !upd_ready)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomised and directed bench for seg7_scan_capture against a run-length
// reference model of the capture and handshake rules.
module tb_seg7_scan_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_n = 7'h7F;
    logic [ND-1:0] dig_sel = '0;
    logic          upd_ready = 1'b1;
    logic          ovr_clr = 1'b0;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_err;
    logic          upd_valid;
    logic [1:0]    upd_idx;
    logic [3:0]    upd_code;
    logic          overrun;

    seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_n     (seg_n),
        .dig_sel   (dig_sel),
        .upd_ready (upd_ready),
        .ovr_clr   (ovr_clr),
        .digits    (digits),
        .digit_err (digit_err),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_code  (upd_code),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // pattern for each code; slot 14 holds a pattern that is not recognised
    logic [6:0] pat [16];

    logic [3:0]  m_digits [ND];
    logic [ND-1:0] m_err;
    logic        m_valid, m_ovr;
    logic [1:0]  m_idx;
    logic [3:0]  m_code;
    logic [10:0] m_prev;
    int          m_run;

    int accepted [$];

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int c = 0; c < 14; c++)
            if (s == pat[c]) return {1'b0, 4'(c)};
        if (s == 7'b1111111) return {1'b0, 4'hF};
        return {1'b1, 4'hE};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_digits[i] = 4'hF;
        m_err   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_idx   = '0;
        m_code  = '0;
        m_prev  = {4'b0, 7'h7F};
        m_run   = 0;
    endtask

    task automatic model_update();
        logic [10:0] cur;
        logic [4:0]  d;
        logic        v, set;
        int          idx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cur = {dig_sel, seg_n};
        v   = $onehot(dig_sel);
        if (!v) m_run = 0;
        else if (cur == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else m_run = 1;
        m_prev = cur;
        set = 1'b0;
        if (v && m_run == SC) begin
            d = ref_decode(seg_n);
            idx = 0;
            for (int i = 0; i < ND; i++) if (dig_sel[i]) idx = i;
            set = m_valid && !upd_ready;
            m_digits[idx] = d[3:0];
            m_err[idx]    = d[4];
            m_valid = 1'b1;
            m_idx   = 2'(idx);
            m_code  = d[3:0];
        end else if (m_valid && upd_ready) begin
            m_valid = 1'b0;
        end
        if (set) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
    endtask

    task automatic compare_all();
        check("digits", 32'(digits), 32'({m_digits[3], m_digits[2], m_digits[1], m_digits[0]}));
        check("digit_err", 32'(digit_err), 32'(m_err));
        check("upd_valid", 32'(upd_valid), 32'(m_valid));
        if (m_valid) begin
            check("upd_idx", 32'(upd_idx), 32'(m_idx));
            check("upd_code", 32'(upd_code), 32'(m_code));
        end
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // one clock: model advances on the edge, DUT compared on the falling edge
    task automatic step();
        logic pv;
        logic [1:0] pidx;
        pv   = upd_valid && rst_n;
        pidx = upd_idx;
        @(posedge clk);
        if (pv && upd_ready) accepted.push_back(int'(pidx));
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [ND-1:0] sel, input logic [6:0] s, input int n);
        dig_sel = sel;
        seg_n   = s;
        for (int k = 0; k < n; k++) step();
    endtask

    logic [15:0] saved;

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
        pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
        pat[8] = 7'b0000000; pat[9] = 7'b0010000; pat[10] = 7'b0001000; pat[11] = 7'b0000011;
        pat[12] = 7'b1000110; pat[13] = 7'b0100001; pat[14] = 7'b0000110; pat[15] = 7'b1111111;
        model_reset();

        @(negedge clk);
        compare_all();
        check("rst_digits", 32'(digits), 32'hFFFF);
        check("rst_valid", 32'(upd_valid), 32'h0);
        rst_n = 1'b1;

        // single capture, then holding produces no further event
        upd_ready = 1'b0;
        hold(4'b0001, pat[2], 4);
        check("t1_digit0", 32'(digits[3:0]), 32'h2);
        check("t1_valid", 32'(upd_valid), 32'h1);
        check("t1_idx", 32'(upd_idx), 32'h0);
        check("t1_code", 32'(upd_code), 32'h2);
        upd_ready = 1'b1;
        hold(4'b0001, pat[2], 6);
        check("t1_no_second", 32'(upd_valid), 32'h0);

        // scan all digits with ready held high
        accepted.delete();
        hold(4'b0001, pat[1], 4);
        hold(4'b0010, pat[2], 4);
        hold(4'b0100, pat[3], 4);
        hold(4'b1000, pat[4], 5);
        check("t2_digits", 32'(digits), 32'h4321);
        check("t2_overrun", 32'(overrun), 32'h0);
        check("t2_events", 32'(accepted.size()), 32'd4);
        for (int i = 0; i < accepted.size() && i < 4; i++)
            check("t2_order", 32'(accepted[i]), 32'(i));

        // unrecognised pattern, then blank
        hold(4'b0010, 7'b0101010, 4);
        check("t3_err_code", 32'(digits[7:4]), 32'hE);
        check("t3_err_flag", 32'(digit_err[1]), 32'h1);
        hold(4'b0010, 7'b1111111, 4);
        check("t3_blank_code", 32'(digits[7:4]), 32'hF);
        check("t3_blank_flag", 32'(digit_err[1]), 32'h0);
        step();

        // overrun while the consumer stalls
        upd_ready = 1'b0;
        hold(4'b0001, pat[7], 4);
        hold(4'b0010, pat[9], 4);
        check("t4_idx", 32'(upd_idx), 32'h1);
        check("t4_code", 32'(upd_code), 32'h9);
        check("t4_overrun", 32'(overrun), 32'h1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("t4_ovr_clr", 32'(overrun), 32'h0);
        upd_ready = 1'b1;
        step();

        // invalid selects never capture; a glitch restarts the window
        saved = digits;
        hold(4'b0011, pat[5], 10);
        hold(4'b0000, pat[5], 10);
        check("t5_no_capture", 32'(digits), 32'(saved));
        hold(4'b0100, pat[6], 2);
        hold(4'b0100, pat[8], 1);
        hold(4'b0100, pat[6], 3);
        check("t5_before", 32'(digits[11:8]), 32'h3);
        step();
        check("t5_after", 32'(digits[11:8]), 32'h6);
        step();

        // reset in the middle of a window
        hold(4'b0010, pat[0], 2);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("t6_rst_digits", 32'(digits), 32'hFFFF);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        hold(4'b0010, pat[0], 3);
        check("t6_no_early", 32'(upd_valid), 32'h0);
        step();
        check("t6_fresh", 32'(digits[7:4]), 32'h0);
        check("t6_valid", 32'(upd_valid), 32'h1);

        // randomised scan traffic
        for (int seg_i = 0; seg_i < 300; seg_i++) begin
            int r, dur;
            logic [ND-1:0] s;
            logic [6:0] p;
            r = int'($urandom_range(0, 7));
            if (r < 6) s = ND'(1) << $urandom_range(0, ND - 1);
            else if (r == 6) s = '0;
            else s = ND'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) p = pat[$urandom_range(0, 15)];
            else p = 7'($urandom_range(0, 127));
            dur = int'($urandom_range(1, 7));
            dig_sel = s;
            seg_n   = p;
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
            end
            for (int k = 0; k < dur; k++) begin
                upd_ready = ($urandom_range(0, 3) != 0);
                ovr_clr   = ($urandom_range(0, 15) == 0);
                step();
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
